// File: rtl/eq_mixer_mc_if.sv
// eq_mixer_mc_if: sample/gain input bus and mixed-output bus of the eq_mixer_mc mixer.
//   in_vld     strobe: band_smpl/band_gain/vol hold a new sample set
//   band_smpl  signed band samples, ch c band b at [(c*NUM_BANDS+b)*16 +: 16]
//   band_gain  unsigned Q1.11 gain per band, shared by all channels
//   vol        unsigned Q1.11 master volume
//   out_vld    strobe: out_smpl/level updated
//   out_smpl   signed mixed output per channel (16 bits each)
//   busy       a sample set is being processed
//   overrun    in_vld arrived while busy (ignored)
//   level      thermometer LED bar per channel (8 bits each)
interface eq_mixer_mc_if #(
    parameter int NUM_CH    = 2,
    parameter int NUM_BANDS = 5
);
    logic                            in_vld;
    logic [NUM_CH*NUM_BANDS*16-1:0]  band_smpl;
    logic [NUM_BANDS*12-1:0]         band_gain;
    logic [11:0]                     vol;
    logic                            out_vld;
    logic [NUM_CH*16-1:0]            out_smpl;
    logic                            busy;
    logic                            overrun;
    logic [NUM_CH*8-1:0]             level;

    modport master (
        output in_vld, band_smpl, band_gain, vol,
        input  out_vld, out_smpl, busy, overrun, level
    );

    modport slave (
        input  in_vld, band_smpl, band_gain, vol,
        output out_vld, out_smpl, busy, overrun, level
    );
endinterface

// File: rtl/eq_mixer_mc.sv
// eq_mixer_mc: N-channel, M-band gain/sum/volume mixer with peak meters.
// A single shared signed multiplier is time-multiplexed over every band of
// every channel (one band per cycle), followed by one volume cycle per channel.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    eq_mixer_mc_if slave: sample set in, mixed samples / status / LED bars out
module eq_mixer_mc #(
    parameter int NUM_CH      = 2,
    parameter int NUM_BANDS   = 5,
    parameter int DECAY_SMPLS = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    eq_mixer_mc_if.slave bus
);
    localparam int AW  = 18 + $clog2(NUM_BANDS);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW  = $clog2(NUM_BANDS);
    localparam int DW  = (DECAY_SMPLS > 1) ? $clog2(DECAY_SMPLS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, VOL, DONE} state_t;

    state_t                          state_q, state_d;
    logic [NUM_CH*NUM_BANDS*16-1:0]  smpl_q;
    logic [NUM_BANDS*12-1:0]         gain_q;
    logic [11:0]                     vol_q;
    logic [CHW-1:0]                  ch_q;
    logic [BW-1:0]                   band_q;
    logic signed [AW-1:0]            acc_q, acc_d;
    logic signed [15:0]              res_q [NUM_CH];
    logic signed [15:0]              res_all [NUM_CH];
    logic [NUM_CH*16-1:0]            out_smpl_q;
    logic                            out_vld_q;
    logic [14:0]                     peak_q [NUM_CH];
    logic [14:0]                     peak_d [NUM_CH];
    logic [NUM_CH*8-1:0]             level_q, level_d;
    logic [DW-1:0]                   dcnt_q;

    logic                            last_band, last_ch, fin, decay;
    logic signed [15:0]              cur_smpl, acc_sat, vres;
    logic [11:0]                     cur_gain;
    logic signed [28:0]              mac_prod, mac_term, vol_prod;
    logic [14:0]                     mag, held;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32767)       return 16'sh7fff;
        else if (x < -32768) return 16'sh8000;
        else                 return x[15:0];
    endfunction

    // Thermometer bar from the highest set bit of p[14:7].
    function automatic logic [7:0] bar(input logic [14:0] p);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (p[7+i]) r = 8'hFF >> (7 - i);
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        last_band = (band_q == BW'(NUM_BANDS - 1));
        last_ch   = (ch_q == CHW'(NUM_CH - 1));
        case (state_q)
            IDLE:    if (bus.in_vld) state_d = MAC;
            MAC:     if (last_band) state_d = VOL;
            VOL:     state_d = last_ch ? DONE : MAC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_smpl = smpl_q[(int'(ch_q) * NUM_BANDS + int'(band_q)) * 16 +: 16];
        cur_gain = gain_q[int'(band_q) * 12 +: 12];
        mac_prod = cur_smpl * $signed({1'b0, cur_gain});
        mac_term = mac_prod >>> 11;
        acc_d    = acc_q + AW'(mac_term);
        acc_sat  = sat16(32'(acc_q));
        vol_prod = acc_sat * $signed({1'b0, vol_q});
        vres     = sat16(32'(vol_prod >>> 11));
        fin      = (state_q == VOL) && last_ch;
        decay    = (dcnt_q == DW'(DECAY_SMPLS - 1));
        level_d  = '0;
        mag      = '0;
        held     = '0;
        // The last channel's result is still combinational when the set finishes,
        // so outputs and peaks are loaded from it directly on that edge.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            res_all[c] = (c == NUM_CH - 1) ? vres : res_q[c];
            if (res_all[c] == -16'sd32768) mag = 15'h7fff;
            else if (res_all[c][15])       mag = 15'(-res_all[c]);
            else                           mag = res_all[c][14:0];
            held      = decay ? (peak_q[c] >> 1) : peak_q[c];
            peak_d[c] = (held > mag) ? held : mag;
            level_d[c*8 +: 8] = bar(peak_d[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_q     <= '0;
            gain_q     <= '0;
            vol_q      <= '0;
            ch_q       <= '0;
            band_q     <= '0;
            acc_q      <= '0;
            out_smpl_q <= '0;
            out_vld_q  <= 1'b0;
            level_q    <= '0;
            dcnt_q     <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                res_q[c]  <= '0;
                peak_q[c] <= '0;
            end
        end else begin
            out_vld_q <= fin;
            case (state_q)
                IDLE: if (bus.in_vld) begin
                    smpl_q <= bus.band_smpl;
                    gain_q <= bus.band_gain;
                    vol_q  <= bus.vol;
                    ch_q   <= '0;
                    band_q <= '0;
                    acc_q  <= '0;
                end
                MAC: begin
                    acc_q  <= acc_d;
                    band_q <= last_band ? '0 : band_q + 1'b1;
                end
                VOL: begin
                    res_q[ch_q] <= vres;
                    acc_q       <= '0;
                    if (!last_ch) ch_q <= ch_q + 1'b1;
                end
                default: ;
            endcase
            if (fin) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    out_smpl_q[c*16 +: 16] <= res_all[c];
                    peak_q[c]              <= peak_d[c];
                end
                level_q <= level_d;
                dcnt_q  <= decay ? '0 : dcnt_q + 1'b1;
            end
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_smpl = out_smpl_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.overrun  = bus.in_vld && (state_q != IDLE);
    assign bus.level    = level_q;
endmodule
